// File: rtl/bus_rr_multi_arbiter_if.sv
// bus_if: driver-FIFO side of the multi-bus arbiter, all buses side by side.
// The master modport is the arbiter; the slave modport is the FIFO/driver side.
// Optional macro BUS_ARB_ERR_EN adds the per-bus err status vector.
interface bus_if #(
    parameter int bits    = 1,
    parameter int drvrs   = 4,
    parameter int pckg_sz = 16
);
    logic [bits-1:0][drvrs-1:0]              pndng;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
    logic [bits-1:0][drvrs-1:0]              pop;
    logic [bits-1:0][drvrs-1:0]              push;
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;
    logic [bits-1:0]                         busy;
`ifdef BUS_ARB_ERR_EN
    logic [bits-1:0]                         err;

    modport master (input pndng, input D_pop, output pop, output push,
                    output D_push, output busy, output err);
    modport slave  (output pndng, output D_pop, input pop, input push,
                    input D_push, input busy, input err);
`else
    modport master (input pndng, input D_pop, output pop, output push,
                    output D_push, output busy);
    modport slave  (output pndng, output D_pop, input pop, input push,
                    input D_push, input busy);
`endif
endinterface

// File: rtl/bus_rr_multi_arbiter.sv
// bus_rr_multi_arbiter: `bits` independent buses, each with `drvrs` driver
// FIFOs. Per bus an IDLE -> POP -> DELIVER FSM grants one pending driver
// (round-robin or fixed priority), pops its head packet and pushes it to the
// destination named in the top byte (unicast, or broadcast excluding source).
// Optional macro BUS_ARB_ERR_EN adds err[b], a one-cycle pulse for packets
// with an invalid destination.
module bus_rr_multi_arbiter #(
    parameter int         bits      = 1,
    parameter int         drvrs     = 4,
    parameter int         pckg_sz   = 16,
    parameter logic [7:0] broadcast = 8'hFF,
    parameter int         ARB_MODE  = 0
) (
    input  logic  clk,
    input  logic  reset,
    bus_if.master bus
);
    localparam int            PW   = $clog2(drvrs);
    localparam logic [PW-1:0] LAST = PW'(drvrs - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DELIVER = 2'd2} state_e;

    state_e                        state_q  [bits];
    state_e                        state_d  [bits];
    logic [PW-1:0]                 grant_q  [bits];
    logic [PW-1:0]                 grant_d  [bits];
    logic [PW-1:0]                 rr_ptr_q [bits];
    logic [PW-1:0]                 rr_ptr_d [bits];
    logic [bits-1:0][drvrs-1:0]    pop_q, pop_d;
    logic [bits-1:0][drvrs-1:0]    push_q, push_d;
    logic [bits-1:0][pckg_sz-1:0]  data_q, data_d;
    logic [bits-1:0]               busy_q, busy_d;
`ifdef BUS_ARB_ERR_EN
    logic [bits-1:0]               err_q, err_d;
`endif
    logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] d_push_w;

    // Next-state, arbitration and delivery decode for every bus.
    always_comb begin
        logic [PW-1:0] sel;
        logic [PW-1:0] cand;
        logic          found;
        logic [7:0]    dest;
        int            idx;
        // NOTE: every _d and scratch variable gets a default before any branch,
        // so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        pop_d    = '0;
        push_d   = '0;
        data_d   = data_q;
        busy_d   = busy_q;
`ifdef BUS_ARB_ERR_EN
        err_d    = '0;
`endif
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        dest  = '0;
        idx   = 0;
        for (int b = 0; b < bits; b++) begin
            sel   = '0;
            found = 1'b0;
            if (ARB_MODE == 0) begin
                // Scan rr_ptr+1 upward, wrapping, first pending driver wins.
                for (int k = 1; k <= drvrs; k++) begin
                    idx = int'(rr_ptr_q[b]) + k;
                    if (idx >= drvrs) idx = idx - drvrs;
                    cand = PW'(idx);
                    if (!found && bus.pndng[b][cand]) begin
                        found = 1'b1;
                        sel   = cand;
                    end
                end
            end else begin
                // Fixed priority: lowest pending index wins.
                for (int i = drvrs - 1; i >= 0; i--) begin
                    if (bus.pndng[b][i]) begin
                        found = 1'b1;
                        sel   = PW'(i);
                    end
                end
            end

            case (state_q[b])
                IDLE: begin
                    if (found) begin
                        grant_d[b]     = sel;
                        pop_d[b][sel]  = 1'b1;
                        state_d[b]     = POP;
                        busy_d[b]      = 1'b1;
                    end
                end
                POP: begin
                    // Capture the granted head and decode its destination now
                    // so push is registered for the DELIVER cycle.
                    data_d[b] = bus.D_pop[b][grant_q[b]];
                    dest      = bus.D_pop[b][grant_q[b]][pckg_sz-1 -: 8];
                    if (dest == broadcast) begin
                        push_d[b]             = '1;
                        push_d[b][grant_q[b]] = 1'b0;
                    end else if (int'(dest) < drvrs) begin
                        push_d[b][dest[PW-1:0]] = 1'b1;
                    end else begin
`ifdef BUS_ARB_ERR_EN
                        err_d[b] = 1'b1;
`endif
                    end
                    if (ARB_MODE == 0) rr_ptr_d[b] = grant_q[b];
                    state_d[b] = DELIVER;
                    busy_d[b]  = 1'b1;
                end
                DELIVER: begin
                    state_d[b] = IDLE;
                    busy_d[b]  = 1'b0;
                end
                default: begin
                    state_d[b] = IDLE;
                    busy_d[b]  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; synchronous reset drops any in-flight packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < bits; b++) begin
                state_q[b]  <= IDLE;
                grant_q[b]  <= '0;
                rr_ptr_q[b] <= LAST;
            end
            pop_q  <= '0;
            push_q <= '0;
            // NOTE: the capture register is a plain per-bus flop, not a memory
            // array, so it takes reset like every other register here.
            data_q <= '0;
            busy_q <= '0;
`ifdef BUS_ARB_ERR_EN
            err_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
`ifdef BUS_ARB_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // Every driver on a bus sees the same delivered packet.
    always_comb begin
        for (int b = 0; b < bits; b++)
            for (int i = 0; i < drvrs; i++)
                d_push_w[b][i] = data_q[b];
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.busy   = busy_q;
    assign bus.D_push = d_push_w;
`ifdef BUS_ARB_ERR_EN
    assign bus.err    = err_q;
`endif

endmodule

// File: tb/tb_bus_rr_multi_arbiter.sv
// Scoreboard bench: unit A (2 buses, round-robin) and unit B (1 bus, fixed
// priority). Channel 0/1 = unit A bus 0/1, channel 2 = unit B bus 0.
module tb_bus_rr_multi_arbiter;
    localparam int K_POP = 0, K_PUSH = 1, K_ERR = 2;
`ifdef BUS_ARB_ERR_EN
    localparam int NK = 3;
`else
    localparam int NK = 2;
`endif

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [15:0] fifo  [12][$];
    exp_t        exp_q [9][$];
    logic [3:0]  pop_seen [3] = '{4'h0, 4'h0, 4'h0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_if #(.bits(2), .drvrs(4), .pckg_sz(16)) if_a ();
    bus_if #(.bits(1), .drvrs(4), .pckg_sz(16)) if_b ();

    bus_rr_multi_arbiter #(.bits(2), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .ARB_MODE(0))
        u_a (.clk(clk), .reset(reset_a), .bus(if_a));
    bus_rr_multi_arbiter #(.bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF), .ARB_MODE(1))
        u_b (.clk(clk), .reset(reset_b), .bus(if_b));

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Drive pndng/D_pop from the FIFO model heads.
    task automatic refresh();
        for (int ch = 0; ch < 3; ch++)
            for (int d = 0; d < 4; d++) begin
                logic        pn;
                logic [15:0] hd;
                pn = (fifo[ch*4+d].size() != 0);
                hd = pn ? fifo[ch*4+d][0] : 16'h0000;
                if (ch == 2) begin
                    if_b.pndng[0][d] = pn;
                    if_b.D_pop[0][d] = hd;
                end else begin
                    if_a.pndng[ch][d] = pn;
                    if_a.D_pop[ch][d] = hd;
                end
            end
    endtask

    task automatic load(int ch, int d, logic [15:0] pkt);
        fifo[ch*4+d].push_back(pkt);
        refresh();
    endtask

    task automatic exp_ev(int ch, int k, logic [3:0] m, logic [15:0] dat, int c);
        exp_t e;
        e.mask = m;
        e.data = dat;
        e.cyc  = c;
        exp_q[ch*NK+k].push_back(e);
    endtask

    function automatic logic [3:0] get_vec(int ch, int k);
        logic [3:0] v;
        v = 4'h0;
        case (k)
            K_POP:  if (ch == 2) v = if_b.pop[0];  else v = if_a.pop[ch];
            K_PUSH: if (ch == 2) v = if_b.push[0]; else v = if_a.push[ch];
`ifdef BUS_ARB_ERR_EN
            K_ERR:  if (ch == 2) v = {3'b000, if_b.err[0]}; else v = {3'b000, if_a.err[ch]};
`endif
            default: v = 4'h0;
        endcase
        return v;
    endfunction

    function automatic logic [15:0] get_dpush(int ch, int d);
        if (ch == 2) return if_b.D_push[0][d];
        return if_a.D_push[ch][d];
    endfunction

    function automatic logic all_empty();
        for (int i = 0; i < 3*NK; i++)
            if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string kname(int k);
        case (k)
            K_POP:   return "pop";
            K_PUSH:  return "push";
            default: return "err";
        endcase
    endfunction

    // Monitor: whenever the DUT shows an event, pop and compare the expectation.
    always @(negedge clk) begin
        for (int ch = 0; ch < 3; ch++) begin
            pop_seen[ch] = get_vec(ch, K_POP);
            for (int k = 0; k < NK; k++) begin
                logic [3:0] obs;
                exp_t       e;
                obs = get_vec(ch, k);
                if (obs != 4'h0) begin
                    if (exp_q[ch*NK+k].size() == 0) begin
                        check($sformatf("ch%0d_%s_unexpected", ch, kname(k)), 32'(obs), 32'h0);
                    end else begin
                        e = exp_q[ch*NK+k].pop_front();
                        check($sformatf("ch%0d_%s_mask", ch, kname(k)), 32'(obs), 32'(e.mask));
                        check($sformatf("ch%0d_%s_cycle", ch, kname(k)), cyc, e.cyc);
                        if (k == K_PUSH)
                            for (int d = 0; d < 4; d++)
                                check($sformatf("ch%0d_dpush%0d", ch, d),
                                      32'(get_dpush(ch, d)), 32'(e.data));
                    end
                end
            end
        end
    end

    // FIFO model: a pop strobe seen during a cycle removes the head after the edge.
    always @(posedge clk) begin
        #1;
        for (int ch = 0; ch < 3; ch++)
            for (int d = 0; d < 4; d++)
                if (pop_seen[ch][d] && fifo[ch*4+d].size() != 0)
                    fifo[ch*4+d].delete(0);
        for (int ch = 0; ch < 3; ch++) pop_seen[ch] = 4'h0;
        refresh();
    end

    task automatic wait_drain(string name, int budget);
        int left;
        left = budget;
        while (!all_empty() && left > 0) begin
            @(posedge clk);
            left--;
        end
        check({name, "_drain"}, 32'(all_empty()), 32'h1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n;
        reset_a = 1'b1;
        reset_b = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;

        // Reset state and 20 idle cycles.
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++)
            for (int d = 0; d < 4; d++)
                check($sformatf("reset_dpush_ch%0d_%0d", ch, d), 32'(get_dpush(ch, d)), 32'h0);
        for (int i = 0; i < 20; i++) begin
            check("idle_busy", 32'({if_b.busy, if_a.busy}), 32'h0);
            check("idle_pop_push", 32'({if_b.pop, if_b.push, if_a.pop, if_a.push}), 32'h0);
            @(negedge clk);
        end

        // Unicast: driver 1 -> driver 2.
        @(posedge clk); #2; n = cyc;
        load(0, 1, 16'h02AB);
        exp_ev(0, K_POP, 4'b0010, 16'h0, n + 1);
        exp_ev(0, K_PUSH, 4'b0100, 16'h02AB, n + 2);
        @(negedge clk); check("uni_busy_n",  32'(if_a.busy[0]), 32'h0);
        @(negedge clk); check("uni_busy_n1", 32'(if_a.busy[0]), 32'h1);
        @(negedge clk); check("uni_busy_n2", 32'(if_a.busy[0]), 32'h1);
        @(negedge clk); check("uni_busy_n3", 32'(if_a.busy[0]), 32'h0);
        wait_drain("unicast", 20);

        // Broadcast from driver 3 excludes the source.
        @(posedge clk); #2; n = cyc;
        load(0, 3, 16'hFF5A);
        exp_ev(0, K_POP, 4'b1000, 16'h0, n + 1);
        exp_ev(0, K_PUSH, 4'b0111, 16'hFF5A, n + 2);
        wait_drain("bcast", 20);

        // Round-robin: all four drivers pending, 3 packets each.
        @(posedge clk); #2; n = cyc;
        for (int j = 0; j < 3; j++)
            for (int d = 0; d < 4; d++)
                load(0, d, {8'((d + 1) % 4), 4'(d), 4'(j)});
        for (int k = 0; k < 12; k++) begin
            int d, j, dst;
            d = k % 4; j = k / 4; dst = (d + 1) % 4;
            exp_ev(0, K_POP, 4'(1 << d), 16'h0, n + 1 + 3*k);
            exp_ev(0, K_PUSH, 4'(1 << dst), {8'(dst), 4'(d), 4'(j)}, n + 2 + 3*k);
        end
        wait_drain("rr", 60);

        // Two buses of unit A at once.
        @(posedge clk); #2; n = cyc;
        load(0, 2, 16'h0011);
        load(1, 0, 16'h0322);
        exp_ev(0, K_POP, 4'b0100, 16'h0, n + 1);
        exp_ev(0, K_PUSH, 4'b0001, 16'h0011, n + 2);
        exp_ev(1, K_POP, 4'b0001, 16'h0, n + 1);
        exp_ev(1, K_PUSH, 4'b1000, 16'h0322, n + 2);
        wait_drain("multibus", 20);

        // Invalid destination 0x09: popped, never pushed.
        @(posedge clk); #2; n = cyc;
        load(0, 0, 16'h09CC);
        exp_ev(0, K_POP, 4'b0001, 16'h0, n + 1);
`ifdef BUS_ARB_ERR_EN
        exp_ev(0, K_ERR, 4'b0001, 16'h0, n + 2);
`endif
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("invalid_no_push", 32'(if_a.push[0]), 32'h0);
        wait_drain("invalid", 20);

        // Reset during the POP cycle discards the packet.
        @(posedge clk); #2; n = cyc;
        load(0, 2, 16'h0133);
        exp_ev(0, K_POP, 4'b0100, 16'h0, n + 1);
        @(posedge clk); #2;
        reset_a = 1'b1;
        @(posedge clk); #2;
        reset_a = 1'b0;
        @(negedge clk);
        check("rst_busy",  32'(if_a.busy), 32'h0);
        check("rst_push",  32'(if_a.push[0]), 32'h0);
        check("rst_dpush", 32'(get_dpush(0, 0)), 32'h0);
        @(negedge clk);
        check("rst_push_next", 32'(if_a.push[0]), 32'h0);
        wait_drain("midreset", 20);

        // After reset the round-robin pointer favours driver 0 over driver 3.
        @(posedge clk); #2; n = cyc;
        load(0, 3, 16'h0277);
        load(0, 0, 16'h0388);
        exp_ev(0, K_POP, 4'b0001, 16'h0, n + 1);
        exp_ev(0, K_PUSH, 4'b1000, 16'h0388, n + 2);
        exp_ev(0, K_POP, 4'b1000, 16'h0, n + 4);
        exp_ev(0, K_PUSH, 4'b0100, 16'h0277, n + 5);
        wait_drain("post_reset", 30);

        // Fixed priority: driver 0 wins every arbitration while pending.
        @(posedge clk); #2; n = cyc;
        for (int j = 0; j < 3; j++) begin
            load(2, 0, 16'h0100 | 16'(j));
            load(2, 2, 16'h0320 | 16'(j));
        end
        for (int k = 0; k < 6; k++) begin
            exp_ev(2, K_POP, (k < 3) ? 4'b0001 : 4'b0100, 16'h0, n + 1 + 3*k);
            exp_ev(2, K_PUSH, (k < 3) ? 4'b0010 : 4'b1000,
                   (k < 3) ? (16'h0100 | 16'(k)) : (16'h0320 | 16'(k - 3)), n + 2 + 3*k);
        end
        wait_drain("fixed_prio", 40);

        // Unicast to itself is delivered.
        @(posedge clk); #2; n = cyc;
        load(2, 1, 16'h0155);
        exp_ev(2, K_POP, 4'b0010, 16'h0, n + 1);
        exp_ev(2, K_PUSH, 4'b0010, 16'h0155, n + 2);
        wait_drain("self", 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end
endmodule
